// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory parameters, write-code encodings and the size/range helpers.
package dmem_arbiter_pkg;

    localparam int AWIDTH = 16;
    localparam int DWIDTH = 32;
    localparam int WORDS  = 64;

    // we code: bit2 = write, bits1:0 = access size
    localparam logic       WE_WRITE  = 1'b1;
    localparam logic [2:0] WE_IDLE   = 3'b000;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    // 1/2/4/8 bytes per access
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    // Last byte touched lies past the addressable window; widened so addr+size never wraps.
    function automatic logic out_of_range(input logic [AWIDTH-1:0] addr, input logic [1:0] sz);
        logic [AWIDTH+1:0] last_byte;
        last_byte = {2'b00, addr} + (AWIDTH+2)'(size_bytes(sz)) - (AWIDTH+2)'(1);
        return last_byte > (AWIDTH+2)'(WORDS + 2);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of an external registered-read data RAM.
// Port 0 is the core MemoryAccess stage, port 1 the debug/loader port.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    input  logic [2:0]        we0,
    input  logic [2:0]        we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              stall0,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_qin,
    output logic [2:0]        ram_we,
    input  logic [DWIDTH-1:0] ram_qout
);

    logic              last_q;     // port granted most recently
    logic              pend_q;     // a read was issued last cycle
    logic              own_q;      // port that owns the pending read
    logic              err0_q, err1_q;
    logic [DWIDTH-1:0] rdata0_q, rdata1_q;
    logic [AWIDTH-1:0] addr_q;     // ram_addr holds here when idle

    logic              any_gnt;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_wdata;
    logic [2:0]        w_we;
    logic              w_oor;

    // Port 1 wins when alone, or when both request and port 0 had the last grant.
    function automatic logic rr_pick1(input logic r0, input logic r1, input logic last);
        return r1 & (~r0 | ~last);
    endfunction

    // Grant, winner mux and RAM drive; everything is held quiet during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            gnt1 = rr_pick1(req0, req1, last_q);
            gnt0 = req0 & ~gnt1;
        end
        any_gnt  = gnt0 | gnt1;
        w_addr   = gnt1 ? addr1  : addr0;
        w_wdata  = gnt1 ? wdata1 : wdata0;
        w_we     = gnt1 ? we1    : we0;
        w_oor    = out_of_range(w_addr, w_we[1:0]);
        ram_addr = any_gnt ? w_addr : addr_q;
        ram_qin  = w_wdata;
        ram_we   = (any_gnt && !w_oor) ? w_we : WE_IDLE;
        stall0   = ~rst & req0 & ~gnt0;
    end

    // Response side: rvalid/err come from last cycle's state, suppressed while in reset.
    always_comb begin
        rvalid0 = ~rst & pend_q & ~own_q;
        rvalid1 = ~rst & pend_q &  own_q;
        err0    = ~rst & err0_q;
        err1    = ~rst & err1_q;
        rdata0  = rvalid0 ? ram_qout : rdata0_q;
        rdata1  = rvalid1 ? ram_qout : rdata1_q;
    end

    // Arbitration pointer, pending-read tracking, error pulses and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= 1'b1;
            pend_q   <= 1'b0;
            own_q    <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            addr_q   <= '0;
        end else begin
            if (any_gnt) begin
                last_q <= gnt1;
                addr_q <= w_addr;
            end
            pend_q <= any_gnt & ~w_oor & (w_we[2] != WE_WRITE);
            if (any_gnt && !w_oor && (w_we[2] != WE_WRITE))
                own_q <= gnt1;
            err0_q <= gnt0 & w_oor;
            err1_q <= gnt1 & w_oor;
            if (rvalid0)
                rdata0_q <= ram_qout;
            if (rvalid1)
                rdata1_q <= ram_qout;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered-read RAM.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic              clk;
    logic              rst;
    logic              req0, req1;
    logic [AWIDTH-1:0] addr0, addr1;
    logic [DWIDTH-1:0] wdata0, wdata1;
    logic [2:0]        we0, we1;
    logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall0;
    logic [DWIDTH-1:0] rdata0, rdata1;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_qin;
    logic [2:0]        ram_we;
    logic [DWIDTH-1:0] ram_qout;

    logic [DWIDTH-1:0] mem [0:255];
    int n_chk;
    int n_fail;
    logic [DWIDTH-1:0] exp0, exp1;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .stall0(stall0),
        .ram_addr(ram_addr), .ram_qin(ram_qin), .ram_we(ram_we),
        .ram_qout(ram_qout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: write on the edge, registered read of the current address
    always @(posedge clk) begin
        if (ram_we[2])
            mem[ram_addr[7:0]] <= ram_qin;
        ram_qout <= mem[ram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_qout = '0;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; we0 = 3'b000; we1 = 3'b000;
        cyc(); cyc();

        // requests ignored while in reset
        req0 = 1'b1; we0 = 3'b110; addr0 = 16'd5; wdata0 = 32'hAAAA5555;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_stall0", stall0, 0);
        cyc();
        check("rst_ram_addr", ram_addr, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_err0", err0, 0);
        req0 = 1'b0; rst = 1'b0;

        // core write then read back
        req0 = 1'b1; we0 = 3'b110; addr0 = 16'h10; wdata0 = 32'hDEADBEEF;
        #1;
        check("wr_gnt0", gnt0, 1);
        check("wr_ram_we", ram_we, 3'b110);
        check("wr_ram_addr", ram_addr, 16'h10);
        check("wr_ram_qin", ram_qin, 32'hDEADBEEF);
        cyc();
        check("wr_no_rvalid0", rvalid0, 0);
        we0 = 3'b010;
        #1;
        check("rd_gnt0", gnt0, 1);
        check("rd_ram_we", ram_we, 3'b010);
        cyc();
        req0 = 1'b0;
        check("rd_rvalid0", rvalid0, 1);
        check("rd_rdata0", rdata0, 32'hDEADBEEF);
        check("rd_rdata1", rdata1, 0);
        check("rd_rvalid1", rvalid1, 0);
        cyc();
        check("rd_rvalid0_end", rvalid0, 0);
        check("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

        // reset clears read data; then contention alternates starting with port 0
        rst = 1'b1;
        cyc();
        check("rst2_rdata0", rdata0, 0);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        we0 = 3'b010; we1 = 3'b010; addr0 = 16'h0; addr1 = 16'h8;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cont_gnt0_%0d", k), gnt0, (k % 2 == 0));
            check($sformatf("cont_gnt1_%0d", k), gnt1, (k % 2 == 1));
            check($sformatf("cont_stall0_%0d", k), stall0, (k % 2 == 1));
            cyc();
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc();

        // out-of-range word write on port 1
        req1 = 1'b1; we1 = 3'b110; addr1 = 16'(WORDS + 1); wdata1 = 32'h12345678;
        #1;
        check("oor_gnt1", gnt1, 1);
        check("oor_ram_we", ram_we, 0);
        cyc();
        req1 = 1'b0;
        check("oor_err1", err1, 1);
        check("oor_rvalid1", rvalid1, 0);
        cyc();
        check("oor_err1_end", err1, 0);

        // size boundary at WORDS+2: byte fits, half does not
        req1 = 1'b1; we1 = 3'b000; addr1 = 16'(WORDS + 2);
        #1;
        check("bnd_b_gnt1", gnt1, 1);
        cyc();
        we1 = 3'b001;
        check("bnd_b_rvalid1", rvalid1, 1);
        check("bnd_b_err1", err1, 0);
        #1;
        check("bnd_h_ram_we", ram_we, 0);
        cyc();
        req1 = 1'b0;
        check("bnd_h_err1", err1, 1);
        check("bnd_h_rvalid1", rvalid1, 0);
        exp1 = '0;

        // preload two words from the loader port
        req1 = 1'b1; we1 = 3'b110; addr1 = 16'h0; wdata1 = 32'h11111111;
        cyc();
        addr1 = 16'h8; wdata1 = 32'h22222222;
        cyc();
        req1 = 1'b0;
        check("pre_rdata1_hold", rdata1, exp1);

        // interleaved reads: even cycles port 0 @0x0, odd cycles port 1 @0x8
        exp0 = '0;
        we0 = 3'b010; we1 = 3'b010; addr0 = 16'h0; addr1 = 16'h8;
        for (int i = 0; i < 6; i++) begin
            req0 = (i % 2 == 0);
            req1 = (i % 2 == 1);
            #1;
            check($sformatf("il_gnt_%0d", i), {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
            if (i % 2 == 0) exp0 = 32'h11111111;
            else            exp1 = 32'h22222222;
            check($sformatf("il_rvalid0_%0d", i), rvalid0, (i % 2 == 0));
            check($sformatf("il_rvalid1_%0d", i), rvalid1, (i % 2 == 1));
            check($sformatf("il_rdata0_%0d", i), rdata0, exp0);
            check($sformatf("il_rdata1_%0d", i), rdata1, exp1);
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc();

        // reset the cycle after a granted read: no rvalid, rdata cleared
        req0 = 1'b1; we0 = 3'b010; addr0 = 16'h10;
        #1;
        check("rmr_gnt0", gnt0, 1);
        cyc();
        req0 = 1'b0; rst = 1'b1;
        #1;
        check("rmr_rvalid0_rst", rvalid0, 0);
        cyc();
        rst = 1'b0;
        check("rmr_rvalid0_after", rvalid0, 0);
        check("rmr_rdata0", rdata0, 0);
        cyc();
        check("rmr_rvalid0_late", rvalid0, 0);

        // reset the cycle after an out-of-range request drops the err pulse
        req1 = 1'b1; we1 = 3'b110; addr1 = 16'(WORDS + 1);
        cyc();
        req1 = 1'b0; rst = 1'b1;
        #1;
        check("rme_err1_rst", err1, 0);
        cyc();
        rst = 1'b0;
        check("rme_err1_after", err1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
